fetch_aligner: RTL and testbench
================================

FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 SHALL have parameter RESET_VECTOR, 32'h0000_0000, PC of the first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_valid  output  1  instruction-memory read request.
REQ-005 SHALL have port mem_addr  output  32  word-aligned read address; bits [1:0] always 0.
REQ-006 SHALL have port mem_ready  input  1  request accepted; mem_rdata valid in the same cycle.
REQ-007 SHALL have port mem_rdata  input  32  little-endian read word.
REQ-008 SHALL have port instr  output  32  instruction to decode; compressed instructions zero-extended in {16'b0, hw}.
REQ-009 SHALL have port pc  output  32  address of instr.
REQ-010 SHALL have port instr_valid  output  1  instr/pc hold one complete instruction.
REQ-011 SHALL have port instr_ready  input  1  consumer takes instr this cycle.
REQ-012 SHALL have port redirect  input  1  flush and restart fetch at redirect_pc.
REQ-013 SHALL have port redirect_pc  input  32  new PC; bit 0 ignored, treated as 0.

Function
REQ-014 SHALL hold a halfword queue of at most 3 entries (hw0 oldest) plus a 2-bit count and a 32-bit head PC.
REQ-015 SHALL assert instr_valid combinationally when count>=1 and hw0[1:0]!=2'b11, or when count>=2.
REQ-016 SHALL drive instr={16'b0,hw0} when hw0[1:0]!=2'b11, else {hw1,hw0}; pc = head PC.
REQ-017 SHALL, on instr_valid && instr_ready && !redirect, pop 1 or 2 halfwords and advance head PC by 2 or 4 (mod 2^32).
REQ-018 SHALL use states IDLE (no request), REQ (mem_valid=1, waiting) and DROP (request outstanding, response to be discarded).
REQ-019 SHALL go IDLE->REQ when count, after this cycle's pop, is <=1 and no redirect is pending; mem_addr = fetch address.
REQ-020 SHALL keep mem_valid and mem_addr stable in REQ/DROP until mem_ready; no request is ever cancelled.
REQ-021 SHALL, on mem_ready in REQ, append both halfwords (or only rdata[31:16] if the fetch address came from a redirect with pc[1]=1), advance the fetch address by 4, and go to REQ if count is still <=1, else IDLE.
REQ-022 SHALL allow a pop and an append in the same cycle; queue shifts first, then appends; count never exceeds 3.
REQ-023 SHALL, on redirect, clear the queue, set head PC and fetch address to redirect_pc, and ignore instr_ready that cycle.
REQ-024 SHALL, on redirect while in REQ without mem_ready, go to DROP; on mem_ready in DROP, discard mem_rdata and go to REQ with the new address.
REQ-025 SHALL, on redirect coinciding with mem_ready in REQ, discard that mem_rdata and go to REQ with the new address next cycle.
REQ-026 SHALL, on a further redirect while in DROP, update the restart address and remain in DROP.
REQ-027 SHALL deassert instr_valid on the cycle after a redirect until new data arrives.

Reset
REQ-028 SHALL, while resetn=0, force state IDLE, count=0, head PC and fetch address = RESET_VECTOR, mem_valid=0, instr_valid=0.
REQ-029 SHALL assert mem_valid in the first cycle after resetn rises.

Structure
REQ-030 SHALL place the fetch state enum and RESET_VECTOR default in the shared CPU package.
REQ-031 SHALL be a single module with no sub-modules; the downstream decoder consumes instr/pc under its decode/decoded handshake.

Verification
REQ-032 SHALL test reset at 0, memory word 0 = 32'h00A00093 -> mem_addr 0, then instr=32'h00A00093, pc=0, instr_valid one cycle after mem_ready.
REQ-033 SHALL test word 0 = 32'h45014081 (two compressed) -> instr 32'h00004081 at pc 0, then 32'h00004501 at pc 2.
REQ-034 SHALL test straddling: word 0 = {16'h0093,16'h4081}, word 1 = {16'hxxxx,16'h00A0} -> compressed at pc 0, then 32'h00A00093 at pc 2 only after word 1 arrives.
REQ-035 SHALL test redirect to 32'h0000_0102 while in REQ at addr 8 -> data for 8 discarded, next mem_addr 32'h100, first instr from rdata[31:16] at pc 32'h102.
REQ-036 SHALL test instr_ready held low with queue of 3 -> mem_valid stays 0, instr unchanged; resetn pulsed low mid-REQ -> mem_valid 0 immediately, restart at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_aligner_pkg.sv
// -----------------------------------------------------------------------------
// fetch_aligner_pkg
//   Shared CPU front-end definitions used by the fetch aligner and its bench.
//   Contents:
//     fetch_state_t        - instruction-memory request FSM states
//     DEFAULT_RESET_VECTOR - PC of the first instruction fetched after reset
//     QUEUE_DEPTH          - halfword queue depth of the aligner
//     is_rvc()             - true when a halfword starts a 16-bit instruction
// -----------------------------------------------------------------------------
package fetch_aligner_pkg;

  // IDLE : no memory request outstanding
  // REQ  : request outstanding, response will be appended to the queue
  // DROP : request outstanding, response belongs to a flushed stream
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned QUEUE_DEPTH          = 3;

  // Instructions whose low two bits are not 2'b11 are 16-bit (compressed).
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_aligner.sv
// -----------------------------------------------------------------------------
// fetch_aligner
//   Fetches 32-bit little-endian words from instruction memory and re-cuts
//   them into whole 16-/32-bit instructions through a 3-entry halfword queue.
//
// Ports
//   clk          in   clock, all state updates on posedge
//   resetn       in   asynchronous active-low reset
//   mem_valid    out  read request
//   mem_addr     out  word-aligned read address
//   mem_ready    in   request accepted, mem_rdata valid this cycle
//   mem_rdata    in   read word
//   instr        out  instruction ({16'b0,hw} when compressed)
//   pc           out  address of instr
//   instr_valid  out  instr/pc hold a complete instruction
//   instr_ready  in   consumer takes instr this cycle
//   redirect     in   flush and restart at redirect_pc
//   redirect_pc  in   restart PC (bit 0 ignored)
//   o_dbg_state  out  current request FSM state
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the clock edge. Once mem_valid is raised, mem_valid and mem_addr
// stay constant until mem_ready; a request is never withdrawn. instr_valid is
// combinational from the queue, and instr_ready is ignored while redirect is
// high.
// -----------------------------------------------------------------------------
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic         clk,
  input  logic         resetn,
  output logic         mem_valid,
  output logic [31:0]  mem_addr,
  input  logic         mem_ready,
  input  logic [31:0]  mem_rdata,
  output logic [31:0]  instr,
  output logic [31:0]  pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output fetch_state_t o_dbg_state
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fetch_state_t r_state;
  logic [15:0]  r_q [QUEUE_DEPTH];   // r_q[0] is the oldest halfword
  logic [1:0]   r_count;
  logic [31:0]  r_pc;                // address of r_q[0]
  logic [31:0]  r_fetch_addr;        // next fetch / restart address (bit 1 = start mid-word)
  logic [31:0]  r_mem_addr;          // address of the outstanding request
  logic         r_mem_valid;

  // ---------------------------------------------------------------------------
  // Combinational queue update
  // ---------------------------------------------------------------------------
  logic        w_hw0_rvc;
  logic        w_instr_valid;
  logic        w_pop;
  logic [1:0]  w_pop_cnt;
  logic [1:0]  w_cnt_pop;
  logic        w_resp;
  logic [1:0]  w_app_cnt;
  logic [1:0]  w_cnt_next;
  logic [15:0] w_first_hw;
  logic [15:0] w_sh [QUEUE_DEPTH];
  logic [15:0] w_nq [QUEUE_DEPTH];
  logic [31:0] w_pc_pop;
  logic [31:0] w_fetch_adv;
  logic [31:0] w_redirect_pc;
  logic        w_unused_bits;

  always_comb begin
    w_hw0_rvc     = is_rvc(r_q[0]);
    w_instr_valid = (r_count >= 2'd2) || ((r_count != 2'd0) && w_hw0_rvc);
    w_pop         = w_instr_valid && instr_ready && !redirect;

    w_pop_cnt = 2'd0;
    if (w_pop) w_pop_cnt = w_hw0_rvc ? 2'd1 : 2'd2;
    w_cnt_pop = r_count - w_pop_cnt;

    // Shift out popped halfwords; slots past the new count are don't-care.
    w_sh[0] = r_q[0];
    w_sh[1] = r_q[1];
    w_sh[2] = r_q[2];
    if (w_pop_cnt == 2'd1) begin
      w_sh[0] = r_q[1];
      w_sh[1] = r_q[2];
    end else if (w_pop_cnt == 2'd2) begin
      w_sh[0] = r_q[2];
    end

    // A response only lands in REQ; a redirect in the same cycle discards it.
    w_resp     = (r_state == FETCH_REQ) && mem_ready && !redirect;
    w_first_hw = r_fetch_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_app_cnt  = 2'd0;
    if (w_resp) w_app_cnt = r_fetch_addr[1] ? 2'd1 : 2'd2;

    // Append after the shift, starting at the post-pop count.
    for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
      w_nq[i] = w_sh[i];
      if (w_resp && (i == int'(w_cnt_pop))) begin
        w_nq[i] = w_first_hw;
      end else if (w_resp && !r_fetch_addr[1] && (i == int'(w_cnt_pop) + 1)) begin
        w_nq[i] = mem_rdata[31:16];
      end
    end

    // Requests are only issued with <=1 halfword left, so this stays <=3.
    w_cnt_next = w_cnt_pop + w_app_cnt;

    w_pc_pop      = r_pc + (w_hw0_rvc ? 32'd2 : 32'd4);
    w_fetch_adv   = {r_fetch_addr[31:2] + 30'd1, 2'b00};
    w_redirect_pc = redirect_pc & ~32'd1;
  end

  // Bit 0 of addresses is never meaningful for halfword-aligned fetch.
  assign w_unused_bits = ^{redirect_pc[0], r_fetch_addr[0]};

  // ---------------------------------------------------------------------------
  // FSM, queue and address registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= FETCH_IDLE;
      r_count      <= 2'd0;
      r_pc         <= RESET_VECTOR;
      r_fetch_addr <= RESET_VECTOR;
      r_mem_addr   <= {RESET_VECTOR[31:2], 2'b00};
      r_mem_valid  <= 1'b0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) r_q[i] <= 16'h0000;
    end else if (redirect) begin
      // Flush: queue empties, both the decode PC and fetch PC restart.
      r_count      <= 2'd0;
      r_pc         <= w_redirect_pc;
      r_fetch_addr <= w_redirect_pc;
      case (r_state)
        FETCH_REQ, FETCH_DROP: begin
          if (mem_ready) begin
            // Outstanding request completes now; its data is discarded.
            r_state     <= FETCH_REQ;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {w_redirect_pc[31:2], 2'b00};
          end else begin
            // Request must stay on the bus; remember to drop its data.
            r_state <= FETCH_DROP;
          end
        end
        default: begin
          // IDLE: empty queue starts a request on the following cycle.
          r_state <= FETCH_IDLE;
        end
      endcase
    end else begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) r_q[i] <= w_nq[i];
      r_count <= w_cnt_next;
      if (w_pop) r_pc <= w_pc_pop;
      case (r_state)
        FETCH_IDLE: begin
          if (w_cnt_pop <= 2'd1) begin
            r_state     <= FETCH_REQ;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {r_fetch_addr[31:2], 2'b00};
          end
        end
        FETCH_REQ: begin
          if (mem_ready) begin
            r_fetch_addr <= w_fetch_adv;
            if (w_cnt_next <= 2'd1) begin
              // Back-to-back request for the following word.
              r_state     <= FETCH_REQ;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_fetch_adv;
            end else begin
              r_state     <= FETCH_IDLE;
              r_mem_valid <= 1'b0;
            end
          end
        end
        FETCH_DROP: begin
          if (mem_ready) begin
            // Stale word dropped; reissue at the restart address.
            r_state     <= FETCH_REQ;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {r_fetch_addr[31:2], 2'b00};
          end
        end
        default: begin
          r_state     <= FETCH_IDLE;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_valid   = r_mem_valid;
  assign mem_addr    = r_mem_addr;
  assign instr       = w_hw0_rvc ? {16'h0000, r_q[0]} : {r_q[1], r_q[0]};
  assign pc          = r_pc;
  assign instr_valid = w_instr_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_aligner.sv
// -----------------------------------------------------------------------------
// tb_fetch_aligner
//   Directed bench for fetch_aligner. Inputs change on the falling edge,
//   outputs are sampled on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_aligner;
  import fetch_aligner_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk;
  logic         resetn;
  logic         mem_valid;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic [31:0]  instr;
  logic [31:0]  pc;
  logic         instr_valid;
  logic         instr_ready;
  logic         redirect;
  logic [31:0]  redirect_pc;
  fetch_state_t dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_aligner #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Checker and driver tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    mem_ready   = 1'b0;
    mem_rdata   = 32'h0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  // Bounded wait for a request, then check its address.
  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!mem_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
    chk({tag, "_mem_addr"}, mem_addr, addr);
  endtask

  // One-cycle memory response.
  task automatic mem_resp(input logic [31:0] data);
    mem_ready = 1'b1;
    mem_rdata = data;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic chk_instr(input string tag, input logic [31:0] exp_instr,
                           input logic [31:0] exp_pc);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_instr"}, instr, exp_instr);
    chk({tag, "_pc"}, pc, exp_pc);
  endtask

  // Consume the current instruction in one cycle.
  task automatic take();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    resetn = 1'b0;
    @(negedge clk);

    // --- Reset state and a single 32-bit instruction -------------------------
    do_reset();
    resetn = 1'b0;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(FETCH_IDLE));
    chk("rst_pc", pc, 32'h0);
    resetn = 1'b1;
    tick();
    chk("first_cycle_mem_valid", 32'(mem_valid), 32'd1);
    chk("first_cycle_mem_addr", mem_addr, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'h00A00093;
    chk("resp_cycle_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    mem_ready = 1'b0;
    chk_instr("w32", 32'h00A00093, 32'h0);
    chk("w32_mem_valid_full", 32'(mem_valid), 32'd0);
    take();
    chk("w32_after_take_valid", 32'(instr_valid), 32'd0);
    chk("w32_next_addr", mem_addr, 32'h4);
    chk("w32_next_req", 32'(mem_valid), 32'd1);

    // --- Two compressed instructions in one word -----------------------------
    do_reset();
    wait_req("rvc2", 32'h0);
    mem_resp(32'h45014081);
    chk_instr("rvc2_a", 32'h00004081, 32'h0);
    take();
    chk_instr("rvc2_b", 32'h00004501, 32'h2);
    chk("rvc2_refill_addr", mem_addr, 32'h4);

    // --- 32-bit instruction straddling two words -----------------------------
    do_reset();
    wait_req("strad", 32'h0);
    mem_resp(32'h00934081);
    chk_instr("strad_c", 32'h00004081, 32'h0);
    take();
    chk("strad_wait_valid", 32'(instr_valid), 32'd0);
    chk("strad_wait_pc", pc, 32'h2);
    chk("strad_req_addr", mem_addr, 32'h4);
    mem_ready = 1'b1;
    mem_rdata = 32'hABCD00A0;
    chk("strad_resp_valid", 32'(instr_valid), 32'd0);
    tick();
    mem_ready = 1'b0;
    chk_instr("strad_w", 32'h00A00093, 32'h2);

    // --- Full queue with instr_ready low: no fetch, output held --------------
    repeat (3) tick();
    chk("full_mem_valid", 32'(mem_valid), 32'd0);
    chk("full_state", 32'(dbg_state), 32'(FETCH_IDLE));
    chk_instr("full_hold", 32'h00A00093, 32'h2);
    take();
    chk_instr("full_tail", 32'h0000ABCD, 32'h6);
    chk("full_refill_addr", mem_addr, 32'h8);

    // --- Redirect while a request at 8 is outstanding ------------------------
    do_reset();
    wait_req("rd_w0", 32'h0);
    mem_resp(32'h00A00093);
    take();
    wait_req("rd_w1", 32'h4);
    mem_resp(32'h00A00093);
    take();
    wait_req("rd_w2", 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    chk("rd_state", 32'(dbg_state), 32'(FETCH_DROP));
    chk("rd_hold_valid", 32'(mem_valid), 32'd1);
    chk("rd_hold_addr", mem_addr, 32'h8);
    chk("rd_instr_valid", 32'(instr_valid), 32'd0);
    mem_resp(32'hDEAD0013);
    chk("rd_drop_instr_valid", 32'(instr_valid), 32'd0);
    chk("rd_new_addr", mem_addr, 32'h100);
    chk("rd_new_state", 32'(dbg_state), 32'(FETCH_REQ));
    mem_resp(32'h45011111);
    chk_instr("rd_hi", 32'h00004501, 32'h102);
    chk("rd_next_addr", mem_addr, 32'h104);

    // --- Redirect coinciding with mem_ready ----------------------------------
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    instr_ready = 1'b1;
    mem_ready   = 1'b1;
    mem_rdata   = 32'h00A00093;
    tick();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    mem_ready   = 1'b0;
    chk("rdr_instr_valid", 32'(instr_valid), 32'd0);
    chk("rdr_mem_valid", 32'(mem_valid), 32'd1);
    chk("rdr_mem_addr", mem_addr, 32'h200);
    chk("rdr_pc", pc, 32'h200);

    // --- Asynchronous reset in the middle of a request -----------------------
    resetn = 1'b0;
    #1;
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(FETCH_IDLE));
    chk("arst_pc", pc, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("arst_restart_valid", 32'(mem_valid), 32'd1);
    chk("arst_restart_addr", mem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
